// File: rtl/pspin_hostmem_dma_wr_pkg.sv
// rtl/pspin_hostmem_dma_wr_pkg.sv - shared FSM state and AXI encodings for the host-memory DMA write path
package pspin_hostmem_dma_wr_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_DESC = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/pspin_hostmem_buf_ram.sv
// rtl/pspin_hostmem_buf_ram.sv - burst staging buffer, one full-width write port, one read port per segment
module pspin_hostmem_buf_ram #(
  parameter int DATA_WIDTH     = 512,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 256,
  parameter int RD_ADDR_WIDTH  = 14,
  parameter int DEPTH          = 64,
  parameter int IDX_W          = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [IDX_W-1:0]                    wr_addr,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  input  logic [SEG_COUNT-1:0]                rd_en,
  input  logic [SEG_COUNT*RD_ADDR_WIDTH-1:0]  rd_addr,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_data
);

  localparam logic [RD_ADDR_WIDTH-1:0] DEPTH_A = RD_ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic [RD_ADDR_WIDTH-1:0]            seg_addr;

  // Read word is held until the next read on that segment; out-of-range reads return zero.
  always_comb begin
    rd_data_d = rd_data_q;
    seg_addr  = '0;
    for (int i = 0; i < SEG_COUNT; i++) begin
      seg_addr = rd_addr[i*RD_ADDR_WIDTH +: RD_ADDR_WIDTH];
      if (rd_en[i]) begin
        rd_data_d[i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] = (seg_addr < DEPTH_A) ?
            mem[seg_addr[IDX_W-1:0]][i*SEG_DATA_WIDTH +: SEG_DATA_WIDTH] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pspin_hostmem_dma_wr.sv
// rtl/pspin_hostmem_dma_wr.sv - AXI4 write slave that stages one burst and hands it to a host DMA engine
module pspin_hostmem_dma_wr
  import pspin_hostmem_dma_wr_pkg::*;
#(
  parameter int ADDR_WIDTH         = 64,
  parameter int DATA_WIDTH         = 512,
  parameter int ID_WIDTH           = 8,
  parameter int DMA_LEN_WIDTH      = 16,
  parameter int DMA_TAG_WIDTH      = 16,
  parameter int DMA_IMM_WIDTH      = 32,
  parameter int RAM_SEL_WIDTH      = 4,
  parameter int RAM_ADDR_WIDTH     = 20,
  parameter int RAM_SEG_COUNT      = 2,
  parameter int RAM_SEG_DATA_WIDTH = 256,
  parameter int RAM_SEG_ADDR_WIDTH = RAM_ADDR_WIDTH - $clog2(DATA_WIDTH/8),
  parameter int MAX_BURST          = 64
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ID_WIDTH-1:0]                          s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]                        s_axi_awaddr,
  input  logic [7:0]                                   s_axi_awlen,
  input  logic [2:0]                                   s_axi_awsize,
  input  logic [1:0]                                   s_axi_awburst,
  input  logic                                         s_axi_awlock,
  input  logic [3:0]                                   s_axi_awcache,
  input  logic [2:0]                                   s_axi_awprot,
  input  logic [3:0]                                   s_axi_awqos,
  input  logic [3:0]                                   s_axi_awregion,
  input  logic                                         s_axi_awuser,
  input  logic                                         s_axi_awvalid,
  output logic                                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]                        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]                      s_axi_wstrb,
  input  logic                                         s_axi_wlast,
  input  logic                                         s_axi_wvalid,
  output logic                                         s_axi_wready,
  output logic [ID_WIDTH-1:0]                          s_axi_bid,
  output logic [1:0]                                   s_axi_bresp,
  output logic                                         s_axi_buser,
  output logic                                         s_axi_bvalid,
  input  logic                                         s_axi_bready,
  output logic [ADDR_WIDTH-1:0]                        m_axis_write_desc_dma_addr,
  output logic [RAM_SEL_WIDTH-1:0]                     m_axis_write_desc_ram_sel,
  output logic [RAM_ADDR_WIDTH-1:0]                    m_axis_write_desc_ram_addr,
  output logic [DMA_IMM_WIDTH-1:0]                     m_axis_write_desc_imm,
  output logic                                         m_axis_write_desc_imm_en,
  output logic [DMA_LEN_WIDTH-1:0]                     m_axis_write_desc_len,
  output logic [DMA_TAG_WIDTH-1:0]                     m_axis_write_desc_tag,
  output logic                                         m_axis_write_desc_valid,
  input  logic                                         m_axis_write_desc_ready,
  input  logic [DMA_TAG_WIDTH-1:0]                     s_axis_write_desc_status_tag,
  input  logic [3:0]                                   s_axis_write_desc_status_error,
  input  logic                                         s_axis_write_desc_status_valid,
  input  logic [RAM_SEG_COUNT*RAM_SEL_WIDTH-1:0]       ram_rd_cmd_sel,
  input  logic [RAM_SEG_COUNT*RAM_SEG_ADDR_WIDTH-1:0]  ram_rd_cmd_addr,
  input  logic [RAM_SEG_COUNT-1:0]                     ram_rd_cmd_valid,
  output logic [RAM_SEG_COUNT-1:0]                     ram_rd_cmd_ready,
  output logic [RAM_SEG_COUNT*RAM_SEG_DATA_WIDTH-1:0]  ram_rd_resp_data,
  output logic [RAM_SEG_COUNT-1:0]                     ram_rd_resp_valid,
  input  logic [RAM_SEG_COUNT-1:0]                     ram_rd_resp_ready
);

  localparam int BYTES  = DATA_WIDTH/8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int BUF_AW = $clog2(MAX_BURST);
  localparam int BEAT_W = 9;
  localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_BURST);

  state_t                     state_q, state_d;
  logic [ID_WIDTH-1:0]        id_q, id_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [7:0]                 len_q, len_d;
  logic                       err_size_q, err_size_d;
  logic                       err_strb_q, err_strb_d;
  logic [BEAT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [DMA_TAG_WIDTH-1:0]   tag_cnt_q, tag_cnt_d;
  logic [DMA_TAG_WIDTH-1:0]   cur_tag_q, cur_tag_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic [RAM_SEG_COUNT-1:0]   resp_valid_q, resp_valid_d;
  logic [RAM_SEG_COUNT-1:0]   cmd_ready, cmd_fire;
  logic [BYTES-1:0]           strb_need;
  logic                       strb_bad;
  logic                       buf_we;

  // Only bytes at or above the start offset must be enabled on the first beat.
  assign strb_need = (beat_cnt_q == '0) ? ({BYTES{1'b1}} << addr_q[OFF_W-1:0]) : {BYTES{1'b1}};
  assign strb_bad  = |(strb_need & ~s_axi_wstrb);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    err_size_d = err_size_q;
    err_strb_d = err_strb_q;
    beat_cnt_d = beat_cnt_q;
    tag_cnt_d  = tag_cnt_q;
    cur_tag_d  = cur_tag_q;
    bresp_d    = bresp_q;
    buf_we     = 1'b0;
    case (state_q)
      ST_IDLE: if (s_axi_awvalid) begin
        id_d       = s_axi_awid;
        addr_d     = s_axi_awaddr;
        len_d      = s_axi_awlen;
        err_size_d = (({1'b0, s_axi_awlen} + 9'd1) > MAX_BEATS) ||
                     (s_axi_awsize != 3'(OFF_W)) || (s_axi_awburst != AXI_BURST_INCR);
        err_strb_d = 1'b0;
        beat_cnt_d = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: if (s_axi_wvalid) begin
        buf_we     = beat_cnt_q < MAX_BEATS;
        beat_cnt_d = beat_cnt_q + 1'b1;
        err_strb_d = err_strb_q | strb_bad;
        if (s_axi_wlast) begin
          if (err_size_q || err_strb_d) begin
            bresp_d = AXI_RESP_SLVERR;
            state_d = ST_RESP;
          end else begin
            state_d = ST_DESC;
          end
        end
      end
      ST_DESC: if (m_axis_write_desc_ready) begin
        cur_tag_d = tag_cnt_q;
        tag_cnt_d = tag_cnt_q + 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: if (s_axis_write_desc_status_valid && s_axis_write_desc_status_tag == cur_tag_q) begin
        bresp_d = (s_axis_write_desc_status_error == 4'd0) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        state_d = ST_RESP;
      end
      ST_RESP: if (s_axi_bready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A segment takes a new command only when its response slot is free or draining this cycle.
  always_comb begin
    cmd_ready    = '0;
    resp_valid_d = resp_valid_q;
    for (int i = 0; i < RAM_SEG_COUNT; i++) begin
      cmd_ready[i] = !rst && (state_q == ST_WAIT) && (!resp_valid_q[i] || ram_rd_resp_ready[i]);
      if (cmd_ready[i] && ram_rd_cmd_valid[i]) resp_valid_d[i] = 1'b1;
      else if (ram_rd_resp_ready[i])           resp_valid_d[i] = 1'b0;
    end
  end

  assign cmd_fire = cmd_ready & ram_rd_cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      err_size_q   <= 1'b0;
      err_strb_q   <= 1'b0;
      beat_cnt_q   <= '0;
      tag_cnt_q    <= '0;
      cur_tag_q    <= '0;
      bresp_q      <= AXI_RESP_OKAY;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      err_size_q   <= err_size_d;
      err_strb_q   <= err_strb_d;
      beat_cnt_q   <= beat_cnt_d;
      tag_cnt_q    <= tag_cnt_d;
      cur_tag_q    <= cur_tag_d;
      bresp_q      <= bresp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q   <= id_d;
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  pspin_hostmem_buf_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .SEG_COUNT      (RAM_SEG_COUNT),
    .SEG_DATA_WIDTH (RAM_SEG_DATA_WIDTH),
    .RD_ADDR_WIDTH  (RAM_SEG_ADDR_WIDTH),
    .DEPTH          (MAX_BURST)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (beat_cnt_q[BUF_AW-1:0]),
    .wr_data (s_axi_wdata),
    .rd_en   (cmd_fire),
    .rd_addr (ram_rd_cmd_addr),
    .rd_data (ram_rd_resp_data)
  );

  assign s_axi_awready = !rst && (state_q == ST_IDLE);
  assign s_axi_wready  = !rst && (state_q == ST_DATA);
  assign s_axi_bvalid  = !rst && (state_q == ST_RESP);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_buser   = 1'b0;

  // Descriptor covers the whole burst minus the unused head of the first beat.
  assign m_axis_write_desc_valid    = !rst && (state_q == ST_DESC);
  assign m_axis_write_desc_dma_addr = addr_q;
  assign m_axis_write_desc_ram_sel  = '0;
  assign m_axis_write_desc_ram_addr = RAM_ADDR_WIDTH'(addr_q[OFF_W-1:0]);
  assign m_axis_write_desc_imm      = '0;
  assign m_axis_write_desc_imm_en   = 1'b0;
  assign m_axis_write_desc_len      = DMA_LEN_WIDTH'((32'(len_q) + 32'd1) * 32'(BYTES)) -
                                      DMA_LEN_WIDTH'(addr_q[OFF_W-1:0]);
  assign m_axis_write_desc_tag      = tag_cnt_q;

  assign ram_rd_cmd_ready  = cmd_ready;
  assign ram_rd_resp_valid = resp_valid_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                           s_axi_awregion, s_axi_awuser, ram_rd_cmd_sel};

endmodule

// File: tb/tb_pspin_hostmem_dma_wr.sv
// tb/tb_pspin_hostmem_dma_wr.sv - scenario bench for pspin_hostmem_dma_wr with a burst/tag reference model
module tb_pspin_hostmem_dma_wr;

  localparam int AW = 64, DW = 512, IDW = 8, LW = 16, TW = 16, IW = 32;
  localparam int SW = 4, RAW = 20, SC = 2, SDW = 256, SAW = 14, MB = 64, NB = DW/8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IDW-1:0] awid;    logic [AW-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
  logic [1:0] awburst;     logic awlock; logic [3:0] awcache; logic [2:0] awprot;
  logic [3:0] awqos;       logic [3:0] awregion; logic awuser; logic awvalid, awready;
  logic [DW-1:0] wdata;    logic [NB-1:0] wstrb; logic wlast, wvalid, wready;
  logic [IDW-1:0] bid;     logic [1:0] bresp; logic buser, bvalid, bready;
  logic [AW-1:0] desc_dma_addr; logic [SW-1:0] desc_ram_sel; logic [RAW-1:0] desc_ram_addr;
  logic [IW-1:0] desc_imm; logic desc_imm_en; logic [LW-1:0] desc_len; logic [TW-1:0] desc_tag;
  logic desc_valid, desc_ready;
  logic [TW-1:0] st_tag;   logic [3:0] st_err; logic st_valid;
  logic [SC*SW-1:0] cmd_sel; logic [SC*SAW-1:0] cmd_addr; logic [SC-1:0] cmd_valid, cmd_ready;
  logic [SC*SDW-1:0] resp_data; logic [SC-1:0] resp_valid, resp_ready;

  pspin_hostmem_dma_wr dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
    .s_axi_awqos(awqos), .s_axi_awregion(awregion), .s_axi_awuser(awuser),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .m_axis_write_desc_dma_addr(desc_dma_addr), .m_axis_write_desc_ram_sel(desc_ram_sel),
    .m_axis_write_desc_ram_addr(desc_ram_addr), .m_axis_write_desc_imm(desc_imm),
    .m_axis_write_desc_imm_en(desc_imm_en), .m_axis_write_desc_len(desc_len),
    .m_axis_write_desc_tag(desc_tag), .m_axis_write_desc_valid(desc_valid),
    .m_axis_write_desc_ready(desc_ready),
    .s_axis_write_desc_status_tag(st_tag), .s_axis_write_desc_status_error(st_err),
    .s_axis_write_desc_status_valid(st_valid),
    .ram_rd_cmd_sel(cmd_sel), .ram_rd_cmd_addr(cmd_addr), .ram_rd_cmd_valid(cmd_valid),
    .ram_rd_cmd_ready(cmd_ready), .ram_rd_resp_data(resp_data), .ram_rd_resp_valid(resp_valid),
    .ram_rd_resp_ready(resp_ready)
  );

  int total = 0;
  int bad   = 0;
  int tb_tag = 0;
  bit saw_desc;
  logic [DW-1:0] beat_mem [0:127];
  logic [AW-1:0] d_addr; logic [RAW-1:0] d_ram_addr; logic [LW-1:0] d_len; logic [TW-1:0] d_tag;
  logic [SW-1:0] d_sel;  logic d_imm_en; logic [IW-1:0] d_imm;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [LW-1:0] exp_len(input logic [AW-1:0] a, input int l);
    return LW'(((l + 1) * NB) - int'(a % NB));
  endfunction

  task automatic fill_beats(input int n);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < DW/32; k++) beat_mem[b][k*32 +: 32] = $urandom;
  endtask

  task automatic do_aw(input logic [IDW-1:0] id, input logic [AW-1:0] a, input logic [7:0] l, output bit ok);
    awid = id; awaddr = a; awlen = l; awsize = 3'd6; awburst = 2'b01; awvalid = 1'b1;
    awcache = 4'($urandom); awprot = 3'($urandom); awqos = 4'($urandom); awregion = 4'($urandom);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (awready) begin ok = 1'b1; step(); break; end
      step();
    end
    awvalid = 1'b0;
  endtask

  task automatic do_w(input int n, input logic [NB-1:0] first_strb, output int accepted);
    accepted = 0;
    for (int b = 0; b < n; b++) begin
      wdata = beat_mem[b]; wstrb = (b == 0) ? first_strb : '1; wlast = (b == n-1); wvalid = 1'b1;
      for (int c = 0; c < 50; c++) begin
        if (desc_valid) saw_desc = 1'b1;
        if (wready) begin accepted++; step(); break; end
        step();
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_desc(input int hold, output bit ok, output bit stable);
    ok = 1'b0; stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (desc_valid) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      d_addr = desc_dma_addr; d_ram_addr = desc_ram_addr; d_len = desc_len; d_tag = desc_tag;
      d_sel = desc_ram_sel; d_imm_en = desc_imm_en; d_imm = desc_imm;
      for (int c = 0; c < hold; c++) begin
        step();
        if (!desc_valid || desc_dma_addr !== d_addr || desc_len !== d_len ||
            desc_tag !== d_tag || desc_ram_addr !== d_ram_addr) stable = 1'b0;
      end
      desc_ready = 1'b1; step(); desc_ready = 1'b0;
      tb_tag = (tb_tag + 1) % 65536;
    end
  endtask

  task automatic read_ram(input int seg, input int a, input bit toggle, output logic [SDW-1:0] data, output bit ok);
    ok = 1'b0; data = 'x;
    cmd_addr[seg*SAW +: SAW] = SAW'(a); cmd_sel[seg*SW +: SW] = SW'($urandom); cmd_valid[seg] = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (cmd_ready[seg]) begin ok = 1'b1; break; end
      step();
    end
    step(); cmd_valid[seg] = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
        resp_ready[seg] = toggle ? 1'($urandom % 2) : 1'b1;
        #0;
        if (resp_valid[seg] && resp_ready[seg]) begin
          data = resp_data[seg*SDW +: SDW]; ok = 1'b1; step(); break;
        end
        step();
      end
      resp_ready[seg] = 1'b0;
    end
  endtask

  task automatic send_status(input logic [TW-1:0] t, input logic [3:0] e);
    st_tag = t; st_err = e; st_valid = 1'b1; step(); st_valid = 1'b0;
  endtask

  task automatic wait_b(input int hold, output bit ok, output bit held, output logic [1:0] r, output logic [IDW-1:0] i);
    ok = 1'b0; held = 1'b1; r = 'x; i = 'x;
    for (int c = 0; c < 200; c++) begin
      if (desc_valid) saw_desc = 1'b1;
      if (bvalid) begin ok = 1'b1; break; end
      step();
    end
    if (ok) begin
      r = bresp; i = bid;
      for (int c = 0; c < hold; c++) begin step(); if (!bvalid) held = 1'b0; end
      bready = 1'b1; step(); bready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b exp=0", awready); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b exp=0", wready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", bvalid); end
    total++; if (desc_valid !== 1'b0) begin bad++; $display("FAIL rst_desc_valid got=%b exp=0", desc_valid); end
    total++; if (cmd_ready !== 2'b00) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=00", cmd_ready); end
    total++; if (resp_valid !== 2'b00) begin bad++; $display("FAIL rst_resp_valid got=%b exp=00", resp_valid); end
    rst = 1'b0; step();
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL idle_awready got=%b exp=1", awready); end
    wvalid = 1'b1; wlast = 1'b1; wstrb = '1; step();
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL w_before_aw_wready got=%b exp=0", wready); end
    wvalid = 1'b0; wlast = 1'b0; step();
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL w_before_aw_state got=%b exp=1", awready); end
  endtask

  task automatic test_aligned();
    bit ok, st; int acc; logic [SDW-1:0] rd; logic [1:0] r; logic [IDW-1:0] i;
    fill_beats(4);
    do_aw(8'h3c, 64'h1000, 8'd3, ok);
    total++; if (!ok) begin bad++; $display("FAIL aligned_aw got=timeout exp=handshake"); end
    do_w(4, '1, acc);
    total++; if (acc != 4) begin bad++; $display("FAIL aligned_beats got=%0d exp=4", acc); end
    get_desc(0, ok, st);
    total++; if (!ok) begin bad++; $display("FAIL aligned_desc got=timeout exp=valid"); end
    total++; if (d_len !== exp_len(64'h1000, 3)) begin bad++; $display("FAIL aligned_len got=%0d exp=%0d", d_len, exp_len(64'h1000, 3)); end
    total++; if (d_ram_addr !== '0 || d_addr !== 64'h1000) begin bad++; $display("FAIL aligned_addr got=%h/%h exp=1000/0", d_addr, d_ram_addr); end
    total++; if (d_tag !== TW'(0) || d_sel !== '0 || d_imm_en !== 1'b0 || d_imm !== '0) begin bad++; $display("FAIL aligned_tag got=%0d sel=%0d imm_en=%b exp=0", d_tag, d_sel, d_imm_en); end
    for (int a = 0; a < 4; a++)
      for (int s = 0; s < SC; s++) begin
        read_ram(s, a, 1'b0, rd, ok);
        total++; if (!ok || rd !== beat_mem[a][s*SDW +: SDW]) begin bad++; $display("FAIL aligned_rd%0d_%0d got=%h exp=%h", a, s, rd, beat_mem[a][s*SDW +: SDW]); end
      end
    read_ram(0, 70, 1'b0, rd, ok);
    total++; if (!ok || rd !== '0) begin bad++; $display("FAIL oob_read got=%h exp=0", rd); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL b_before_status got=%b exp=0", bvalid); end
    send_status(16'd0, 4'd0);
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b00 || i !== 8'h3c) begin bad++; $display("FAIL aligned_b got=%b id=%h exp=00 id=3c", r, i); end
  endtask

  task automatic test_unaligned();
    bit ok, st; int acc; logic [SDW-1:0] rd; logic [1:0] r; logic [IDW-1:0] i; logic [NB-1:0] fs;
    fs = '1; fs[15:0] = '0;
    fill_beats(1);
    do_aw(8'h07, 64'h2010, 8'd0, ok);
    do_w(1, fs, acc);
    get_desc(0, ok, st);
    total++; if (!ok || d_len !== exp_len(64'h2010, 0)) begin bad++; $display("FAIL unal_len got=%0d exp=%0d", d_len, exp_len(64'h2010, 0)); end
    total++; if (d_ram_addr !== RAW'(16) || d_tag !== TW'(1)) begin bad++; $display("FAIL unal_desc got=ram_addr %h tag %0d exp=10 tag 1", d_ram_addr, d_tag); end
    for (int s = 0; s < SC; s++) begin
      read_ram(s, 0, 1'b0, rd, ok);
      total++; if (!ok || rd !== beat_mem[0][s*SDW +: SDW]) begin bad++; $display("FAIL unal_rd%0d got=%h exp=%h", s, rd, beat_mem[0][s*SDW +: SDW]); end
    end
    send_status(16'd1, 4'd0);
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b00) begin bad++; $display("FAIL unal_b got=%b exp=00", r); end
  endtask

  task automatic test_oversize();
    bit ok, st; int acc; logic [1:0] r; logic [IDW-1:0] i;
    fill_beats(65);
    saw_desc = 1'b0;
    do_aw(8'h21, 64'h8000, 8'd64, ok);
    do_w(65, '1, acc);
    total++; if (acc != 65) begin bad++; $display("FAIL over_beats got=%0d exp=65", acc); end
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b10 || i !== 8'h21) begin bad++; $display("FAIL over_b got=%b id=%h exp=10 id=21", r, i); end
    total++; if (saw_desc !== 1'b0) begin bad++; $display("FAIL over_desc got=%b exp=0", saw_desc); end
  endtask

  task automatic test_dma_error();
    bit ok, st, quiet; int acc; logic [1:0] r; logic [IDW-1:0] i;
    fill_beats(2);
    do_aw(8'h44, 64'h3000, 8'd1, ok);
    do_w(2, '1, acc);
    get_desc(0, ok, st);
    total++; if (!ok || d_tag !== TW'(tb_tag - 1) || d_len !== exp_len(64'h3000, 1)) begin bad++; $display("FAIL err_desc got=tag %0d len %0d exp=tag %0d len 128", d_tag, d_len, tb_tag - 1); end
    send_status(TW'(tb_tag + 6), 4'd0);
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin if (bvalid) quiet = 1'b0; step(); end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL wrong_tag_ignored got=bvalid exp=quiet"); end
    send_status(TW'(tb_tag - 1), 4'd4);
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b10) begin bad++; $display("FAIL err_b got=%b exp=10", r); end
  endtask

  task automatic test_back_to_back();
    bit ok, st; int acc, nb; logic [SDW-1:0] rd; logic [1:0] r; logic [IDW-1:0] i;
    fill_beats(4);
    do_aw(8'h5a, 64'h4000, 8'd3, ok);
    do_w(4, '1, acc);
    get_desc(10, ok, st);
    total++; if (!ok || st !== 1'b1) begin bad++; $display("FAIL bp_desc_stable got=%b exp=1", st); end
    total++; if (d_len !== exp_len(64'h4000, 3) || d_tag !== TW'(tb_tag - 1)) begin bad++; $display("FAIL bp_desc got=len %0d tag %0d exp=256 tag %0d", d_len, d_tag, tb_tag - 1); end
    for (int a = 0; a < 4; a++)
      for (int s = 0; s < SC; s++) begin
        read_ram(s, a, 1'b1, rd, ok);
        total++; if (!ok || rd !== beat_mem[a][s*SDW +: SDW]) begin bad++; $display("FAIL bp_rd%0d_%0d got=%h exp=%h", a, s, rd, beat_mem[a][s*SDW +: SDW]); end
      end
    send_status(TW'(tb_tag - 1), 4'd0);
    wait_b(5, ok, st, r, i);
    total++; if (!ok || st !== 1'b1 || r !== 2'b00 || i !== 8'h5a) begin bad++; $display("FAIL bp_b got=held %b resp %b id %h exp=1 00 5a", st, r, i); end
    nb = 0;
    for (int c = 0; c < 10; c++) begin if (bvalid) nb++; step(); end
    total++; if (nb != 0) begin bad++; $display("FAIL bp_single_b got=%0d extra exp=0", nb); end
  endtask

  task automatic test_reset_in_wait();
    bit ok, st, quiet; int acc; logic [SDW-1:0] rd; logic [1:0] r; logic [IDW-1:0] i; logic [NB-1:0] fs;
    fill_beats(2);
    do_aw(8'h11, 64'h5000, 8'd1, ok);
    do_w(2, '1, acc);
    get_desc(0, ok, st);
    total++; if (!ok || d_tag !== TW'(4)) begin bad++; $display("FAIL rw_first_tag got=%0d exp=4", d_tag); end
    rst = 1'b1; cmd_valid = '1; step();
    total++; if (awready !== 1'b0 || cmd_ready !== 2'b00) begin bad++; $display("FAIL rw_in_reset got=aw %b cmd %b exp=0 00", awready, cmd_ready); end
    cmd_valid = '0; step(); rst = 1'b0; tb_tag = 0; step();
    send_status(16'd4, 4'd0);
    send_status(16'd0, 4'd0);
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin if (bvalid) quiet = 1'b0; step(); end
    total++; if (quiet !== 1'b1 || awready !== 1'b1) begin bad++; $display("FAIL rw_stale got=quiet %b aw %b exp=1 1", quiet, awready); end
    fill_beats(2);
    fs = '1; fs[31:0] = '0;
    do_aw(8'h12, 64'h6020, 8'd1, ok);
    do_w(2, fs, acc);
    get_desc(0, ok, st);
    total++; if (!ok || d_tag !== TW'(0) || d_len !== exp_len(64'h6020, 1)) begin bad++; $display("FAIL rw_new_desc got=tag %0d len %0d exp=0 96", d_tag, d_len); end
    read_ram(1, 1, 1'b0, rd, ok);
    total++; if (!ok || rd !== beat_mem[1][SDW +: SDW]) begin bad++; $display("FAIL rw_rd got=%h exp=%h", rd, beat_mem[1][SDW +: SDW]); end
    send_status(16'd1, 4'd0);
    send_status(16'd0, 4'd0);
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b00 || i !== 8'h12) begin bad++; $display("FAIL rw_b got=%b id %h exp=00 12", r, i); end
    fill_beats(1);
    do_aw(8'h13, 64'h7000, 8'd0, ok);
    do_w(1, '1, acc);
    get_desc(0, ok, st);
    total++; if (!ok || d_tag !== TW'(1)) begin bad++; $display("FAIL rw_next_tag got=%0d exp=1", d_tag); end
    send_status(16'd1, 4'd0);
    wait_b(0, ok, st, r, i);
    total++; if (!ok || r !== 2'b00) begin bad++; $display("FAIL rw_next_b got=%b exp=00", r); end
  endtask

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd6; awburst = 2'b01; awlock = 1'b0;
    awcache = '0; awprot = '0; awqos = '0; awregion = '0; awuser = 1'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; desc_ready = 1'b0;
    st_tag = '0; st_err = '0; st_valid = 1'b0;
    cmd_sel = '0; cmd_addr = '0; cmd_valid = '0; resp_ready = '0;
    saw_desc = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_oversize();
    test_dma_error();
    test_back_to_back();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
